// File: rtl/tmr_scrub_pkg.sv
// Shared types and helpers for the TMR bank scrubber.
package tmr_scrub_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4
  } state_e;

  // Widest word maj3 handles; narrower callers zero-extend and truncate the result.
  localparam int unsigned MAJ_MAXW = 64;

  function automatic logic [MAJ_MAXW-1:0] maj3(input logic [MAJ_MAXW-1:0] a,
                                               input logic [MAJ_MAXW-1:0] b,
                                               input logic [MAJ_MAXW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_word_voter.sv
// Bitwise majority vote of three copies plus disagreement classification.
module tmr_word_voter
  import tmr_scrub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] vote,
  output logic             mismatch,
  output logic             multi
);

  assign vote     = WIDTH'(maj3(MAJ_MAXW'(a), MAJ_MAXW'(b), MAJ_MAXW'(c)));
  assign mismatch = !((a == b) && (b == c));
  assign multi    = (a != b) && (a != c) && (b != c);

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Scrub sequencer for a triplicated register bank: read, vote, repair, count.
module tmr_scrub_ctrl
  import tmr_scrub_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PERIOD = 1024,
  parameter int unsigned CNTW   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     auto_en,
  input  logic                     usr_req,
  input  logic                     err_clr,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic                     mem_re,
  output logic                     mem_we,
  input  logic [WIDTH-1:0]         mem_rdata_a,
  input  logic [WIDTH-1:0]         mem_rdata_b,
  input  logic [WIDTH-1:0]         mem_rdata_c,
  output logic [WIDTH-1:0]         mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic [CNTW-1:0]          err_cnt,
  output logic                     err_flag,
  output logic                     multi_flag
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(PERIOD);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  vote_q, vote_d;
  logic              wmulti_q, wmulti_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              eflag_q, eflag_d;
  logic              mflag_q, mflag_d;

  logic [WIDTH-1:0]  v_vote;
  logic              v_mismatch;
  logic              v_multi;

  tmr_word_voter #(.WIDTH(WIDTH)) u_voter (
    .a        (mem_rdata_a),
    .b        (mem_rdata_b),
    .c        (mem_rdata_c),
    .vote     (v_vote),
    .mismatch (v_mismatch),
    .multi    (v_multi)
  );

  // Next-state, counters and statistics.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    timer_d  = '0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    vote_d   = vote_q;
    wmulti_d = wmulti_q;
    cnt_d    = cnt_q;
    eflag_d  = eflag_q;
    mflag_d  = mflag_q;

    case (state_q)
      S_IDLE: begin
        if (start || (auto_en && (timer_q == TW'(PERIOD - 1)))) begin
          state_d = S_READ;
          addr_d  = '0;
          busy_d  = 1'b1;
        end else if (auto_en) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_READ: begin
        if (!usr_req) state_d = S_CHECK;
      end
      S_CHECK: begin
        vote_d   = v_vote;
        wmulti_d = v_multi;
        // A user access may have changed the word, so the vote is stale: re-read.
        if (usr_req)         state_d = S_READ;
        else if (v_mismatch) state_d = S_WRITE;
        else                 state_d = S_NEXT;
      end
      S_WRITE: begin
        if (usr_req) begin
          state_d = S_READ;
        end else begin
          state_d = S_NEXT;
          if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
          eflag_d = 1'b1;
          if (wmulti_q) mflag_d = 1'b1;
        end
      end
      S_NEXT: begin
        if (addr_q == AW'(DEPTH - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_clr) begin
      cnt_d   = '0;
      eflag_d = 1'b0;
      mflag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vote_q   <= '0;
      wmulti_q <= 1'b0;
      cnt_q    <= '0;
      eflag_q  <= 1'b0;
      mflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      timer_q  <= timer_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      vote_q   <= vote_d;
      wmulti_q <= wmulti_d;
      cnt_q    <= cnt_d;
      eflag_q  <= eflag_d;
      mflag_q  <= mflag_d;
    end
  end

  // Strobes decode registered state but yield to a same-cycle user access.
  assign mem_re     = (state_q == S_READ)  && !usr_req;
  assign mem_we     = (state_q == S_WRITE) && !usr_req;
  assign mem_addr   = addr_q;
  assign mem_wdata  = vote_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_cnt    = cnt_q;
  assign err_flag   = eflag_q;
  assign multi_flag = mflag_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: bank model, directed scenarios and randomized passes vs a reference model.
module tb_tmr_scrub_ctrl;

  localparam int DEPTH  = 16;
  localparam int PERIOD = 20;

  logic       clk = 1'b0;
  logic       rst, start, auto_en, usr_req, err_clr;
  logic [3:0] mem_addr;
  logic       mem_re, mem_we;
  logic [7:0] mem_rdata_a, mem_rdata_b, mem_rdata_c, mem_wdata;
  logic       busy, done, err_flag, multi_flag;
  logic [7:0] err_cnt;

  tmr_scrub_ctrl #(.WIDTH(8), .DEPTH(DEPTH), .PERIOD(PERIOD), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .usr_req(usr_req),
    .err_clr(err_clr), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b), .mem_rdata_c(mem_rdata_c),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err_cnt(err_cnt),
    .err_flag(err_flag), .multi_flag(multi_flag)
  );

  always #5 clk = ~clk;

  // Bank model and bus monitor (sole writer of the bank arrays).
  logic [7:0] ma [DEPTH];
  logic [7:0] mb [DEPTH];
  logic [7:0] mc [DEPTH];
  logic [7:0] rd_a, rd_b, rd_c;
  logic       poke_en = 1'b0;
  logic [3:0] poke_addr;
  logic [7:0] poke_a, poke_b, poke_c;
  int         cyc = 0, re_cnt = 0, done_cnt = 0, viol = 0;
  int         wlog_a [$];
  logic [7:0] wlog_d [$];

  assign mem_rdata_a = rd_a;
  assign mem_rdata_b = rd_b;
  assign mem_rdata_c = rd_c;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) begin
      ma[poke_addr] <= poke_a; mb[poke_addr] <= poke_b; mc[poke_addr] <= poke_c;
    end else if (mem_we) begin
      ma[mem_addr] <= mem_wdata; mb[mem_addr] <= mem_wdata; mc[mem_addr] <= mem_wdata;
    end
    if (mem_re) begin
      rd_a <= ma[mem_addr]; rd_b <= mb[mem_addr]; rd_c <= mc[mem_addr];
      re_cnt <= re_cnt + 1;
    end
    if (mem_we) begin
      wlog_a.push_back(int'(mem_addr));
      wlog_d.push_back(mem_wdata);
    end
    if (done) done_cnt <= done_cnt + 1;
    if ((mem_re && mem_we) || (usr_req && (mem_re || mem_we))) viol <= viol + 1;
  end

  // Reference state: intended bank contents and expected statistics.
  logic [7:0] sa [DEPTH];
  logic [7:0] sb [DEPTH];
  logic [7:0] sc [DEPTH];
  int         exp_cnt = 0;
  bit         exp_eflag = 1'b0, exp_mflag = 1'b0;
  int         tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] vote_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'(a[k]) + int'(b[k]) + int'(c[k]);
      r[k] = (n >= 2);
    end
    return r;
  endfunction

  task automatic load_word(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
    sa[i] = a; sb[i] = b; sc[i] = c;
    poke_en = 1'b1; poke_addr = 4'(i); poke_a = a; poke_b = b; poke_c = c;
    step();
    poke_en = 1'b0;
  endtask

  // mode 0: all copies agree; 1: one copy corrupted; 2: mixed incl. three-way splits.
  task automatic corrupt_all(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] v, m;
      int sel;
      v = 8'($urandom);
      m = 8'($urandom_range(1, 255));
      sel = (mode == 0) ? 0 : (mode == 1) ? $urandom_range(1, 3) : $urandom_range(0, 5);
      case (sel)
        1: load_word(i, v ^ m, v, v);
        2: load_word(i, v, v ^ m, v);
        3: load_word(i, v, v, v ^ m);
        4: load_word(i, v, v ^ m, v ^ 8'(m + 8'd1) ^ m ^ m);
        default: load_word(i, v, v, v);
      endcase
    end
  endtask

  task automatic run_pass(input string tag, input bit rand_usr, input int ua);
    int         ea [$];
    logic [7:0] ev [$];
    int         nm, c0, re0, w0, d0, k, bad;
    bit         any_multi, armed, hit, det;
    nm = 0; any_multi = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(sa[i] == sb[i] && sb[i] == sc[i])) begin
        ea.push_back(i);
        ev.push_back(vote_ref(sa[i], sb[i], sc[i]));
        nm++;
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        if (sa[i] != sb[i] && sa[i] != sc[i] && sb[i] != sc[i]) any_multi = 1'b1;
      end
    end
    if (nm > 0) exp_eflag = 1'b1;
    if (any_multi) exp_mflag = 1'b1;

    re0 = re_cnt; w0 = wlog_a.size(); d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    armed = 1'b0; hit = 1'b0; k = 0;
    while (!done && k < 3000) begin
      det = (ua >= 0) && !hit && !armed && mem_re && (mem_addr == 4'(ua));
      if (rand_usr) usr_req = ($urandom_range(0, 3) == 0);
      else begin
        usr_req = armed;
        if (armed) hit = 1'b1;
        armed = det;
      end
      step();
      k++;
    end
    usr_req = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    if (!rand_usr) begin
      check({tag, "_latency"}, 32'(cyc - c0), 32'(3 * DEPTH + nm + ((ua >= 0) ? 2 : 0)));
      check({tag, "_reads"}, 32'(re_cnt - re0), 32'(DEPTH + ((ua >= 0) ? 1 : 0)));
    end
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_nwrites"}, 32'(wlog_a.size() - w0), 32'(nm));
    if (wlog_a.size() - w0 == nm) begin
      for (int i = 0; i < nm; i++) begin
        check({tag, "_waddr"}, 32'(wlog_a[w0 + i]), 32'(ea[i]));
        check({tag, "_wdata"}, 32'(wlog_d[w0 + i]), 32'(ev[i]));
      end
    end
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    check({tag, "_err_flag"}, 32'(err_flag), 32'(exp_eflag));
    check({tag, "_multi_flag"}, 32'(multi_flag), 32'(exp_mflag));
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] v;
      v = vote_ref(sa[i], sb[i], sc[i]);
      sa[i] = v; sb[i] = v; sc[i] = v;
      if (ma[i] !== v || mb[i] !== v || mc[i] !== v) bad++;
    end
    check({tag, "_bank_repaired"}, 32'(bad), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_strobe_rules"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int k, cE, b1, f1, b2, d0;
    rst = 1'b1; start = 1'b0; auto_en = 1'b0; usr_req = 1'b0; err_clr = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_flags", 32'({err_flag, multi_flag}), 32'd0);
    rst = 1'b0;

    // Clean bank: 16 reads, no writes, done 48 cycles after start.
    corrupt_all(0);
    run_pass("t1", 1'b0, -1);

    // Single-copy upset on word 5.
    load_word(5, 8'h3C, 8'h3C, 8'h3D);
    run_pass("t2", 1'b0, -1);
    check("t2_cnt_const", 32'(err_cnt), 32'd1);
    check("t2_multi_const", 32'(multi_flag), 32'd0);
    check("t2_wdata_const", 32'(wlog_d[wlog_d.size() - 1]), 32'h3C);

    // Three-way disagreement on word 2.
    load_word(2, 8'h01, 8'h02, 8'h04);
    run_pass("t3", 1'b0, -1);
    check("t3_wdata_const", 32'(wlog_d[wlog_d.size() - 1]), 32'h00);
    check("t3_multi_const", 32'(multi_flag), 32'd1);

    // User access during CHECK of a mismatching word forces a re-read.
    load_word(7, 8'hA5, 8'h5A, 8'hA5);
    run_pass("t4", 1'b0, 7);

    // Periodic passes, then reset mid-pass.
    corrupt_all(0);
    auto_en = 1'b1;
    cE = cyc; k = 0;
    while (!busy && k < 200) begin step(); k++; end
    b1 = cyc;
    check("t5_first_start", 32'(b1 - cE), 32'(PERIOD));
    k = 0;
    while (busy && k < 200) begin step(); k++; end
    f1 = cyc;
    check("t5_pass_len", 32'(f1 - b1), 32'(3 * DEPTH));
    check("t5_done", 32'(done), 32'd1);
    k = 0;
    while (!busy && k < 200) begin step(); k++; end
    b2 = cyc;
    check("t5_gap", 32'(b2 - f1), 32'(PERIOD));
    repeat (10) step();
    check("t5_mid_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    auto_en = 1'b0;
    step();
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_addr", 32'(mem_addr), 32'd0);
    check("t5_rst_strobes", 32'({mem_re, mem_we, done}), 32'd0);
    check("t5_rst_stats", 32'({err_cnt, err_flag, multi_flag}), 32'd0);
    rst = 1'b0;
    exp_cnt = 0; exp_eflag = 1'b0; exp_mflag = 1'b0;
    repeat (60) step();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);

    // Saturation: 19 passes x 16 corrections.
    for (int p = 0; p < 19; p++) begin
      corrupt_all(1);
      run_pass("t6_sat", 1'b0, -1);
    end
    check("t6_saturated", 32'(err_cnt), 32'd255);

    // err_clr coinciding with a write wins.
    load_word(3, 8'h55, 8'h55, 8'hAA);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!mem_we && k < 200) begin step(); k++; end
    check("t6_we_seen", 32'(mem_we), 32'd1);
    check("t6_we_addr", 32'(mem_addr), 32'd3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t6_clr_cnt", 32'(err_cnt), 32'd0);
    check("t6_clr_flags", 32'({err_flag, multi_flag}), 32'd0);
    k = 0;
    while (!done && k < 200) begin step(); k++; end
    check("t6_clr_done", 32'(done), 32'd1);
    check("t6_clr_repair", 32'({ma[3], mc[3]}), 32'h5555);
    sc[3] = 8'h55;
    exp_cnt = 0; exp_eflag = 1'b0; exp_mflag = 1'b0;
    step();

    // Randomized banks, alternating random user traffic and a single directed stall.
    for (int r = 0; r < 8; r++) begin
      corrupt_all(2);
      if (r % 2 == 1) run_pass("rnd_usr", 1'b1, -1);
      else            run_pass("rnd", 1'b0, $urandom_range(0, DEPTH - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
